// File: rtl/fft_pkg.sv
// -----------------------------------------------------------------------------
// fft_pkg
//   Shared definitions for the SDF FFT stage controller.
//   - DEFAULT_DATA_W : default width of one real/imag sample component
//   - ENC_*          : 2-bit encodings of the stage controller states
//   - fsm_state_e    : state enum built on those encodings
//   - tw_stride()    : twiddle ROM address step between consecutive fill slots
// -----------------------------------------------------------------------------
package fft_pkg;

  localparam int DEFAULT_DATA_W = 16;

  localparam logic [1:0] ENC_IDLE  = 2'd0;
  localparam logic [1:0] ENC_PRIME = 2'd1;
  localparam logic [1:0] ENC_RUN   = 2'd2;
  localparam logic [1:0] ENC_DRAIN = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = ENC_IDLE,
    S_PRIME = ENC_PRIME,
    S_RUN   = ENC_RUN,
    S_DRAIN = ENC_DRAIN
  } fsm_state_e;

  // A stage with delay 2^log_d inside an N=2^log_n FFT steps through the
  // N/2-entry twiddle table in strides of 2^(log_n-1-log_d).
  function automatic int tw_stride(input int log_n, input int log_d);
    return 1 << (log_n - 1 - log_d);
  endfunction

endpackage

// File: rtl/fft_phase_cnt.sv
// -----------------------------------------------------------------------------
// fft_phase_cnt
//   Enable-gated binary counter that wraps from 2^W-1 to 0, with a synchronous
//   clear and a terminal-count flag.
//   Ports:
//     clk    in   clock, rising edge
//     rst    in   synchronous active-high reset
//     i_clr  in   synchronous clear to 0 (wins over i_en)
//     i_en   in   advance by one
//     o_cnt  out  W-bit count value
//     o_tc   out  1 when the count is at its maximum (2^W-1)
// -----------------------------------------------------------------------------
module fft_phase_cnt #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      // NOTE: state is updated with <= so every register samples pre-edge values.
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = &r_cnt;

endmodule

// File: rtl/fft_sdf_stage_ctrl.sv
// -----------------------------------------------------------------------------
// fft_sdf_stage_ctrl
//   Control unit for one radix-2 single-path delay-feedback FFT stage with a
//   delay line of D = 2^LOG_D samples. Each group of 2D samples is D fill
//   slots (input goes into the delay line, the delay line's previous butterfly
//   difference comes out) followed by D butterfly slots (sums come out).
//   After the final input the stage self-advances D cycles to drain the line.
//   Ports:
//     clk, rst              clock / synchronous active-high reset
//     valid_i, last_i       input sample strobe / final sample of the stream
//     inv_i                 inverse transform, captured on the stream's first accept
//     data_in_r/_i          input sample
//     data_out_r/_i         registered sample for butterfly port A (0 while draining)
//     valid_o, last_o       output sample strobe / final output of the stream
//     bf_en, fb_sel         butterfly phase and delay-line feedback select
//     tw_addr               twiddle ROM index for fill-slot outputs
//     tw_conj               conjugate twiddles (inverse transform)
//     state                 IDLE=0, PRIME=1, RUN=2, DRAIN=3
//     err_o                 sticky: last_i arrived off a 2D-group boundary
// -----------------------------------------------------------------------------
module fft_sdf_stage_ctrl
  import fft_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int LOG_D  = 2,
  parameter int LOG_N  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic              last_i,
  input  logic              inv_i,
  input  logic [DATA_W-1:0] data_in_r,
  input  logic [DATA_W-1:0] data_in_i,
  output logic [DATA_W-1:0] data_out_r,
  output logic [DATA_W-1:0] data_out_i,
  output logic              valid_o,
  output logic              last_o,
  output logic              bf_en,
  output logic              fb_sel,
  output logic [LOG_N-2:0]  tw_addr,
  output logic              tw_conj,
  output logic [1:0]        state,
  output logic              err_o
);

  localparam int D         = 1 << LOG_D;
  localparam int CNT_W     = LOG_D + 1;
  localparam int TW_W      = LOG_N - 1;
  localparam int TW_STRIDE = tw_stride(LOG_N, LOG_D);

  // Count value at the D-th accept: the delay line is full after it.
  localparam logic [CNT_W-1:0] CNT_PRIME_END = CNT_W'(D - 1);

  fsm_state_e        r_state;
  logic [DATA_W-1:0] r_data_r;
  logic [DATA_W-1:0] r_data_i;
  logic              r_valid;
  logic              r_last;
  logic              r_ph;
  logic [TW_W-1:0]   r_tw_addr;
  logic              r_tw_conj;
  logic              r_err;

  logic              w_adv;
  logic              w_accept;
  logic              w_last_acc;
  logic              w_drain;
  logic              w_drain_done;
  logic [CNT_W-1:0]  w_cnt;
  logic              w_cnt_tc;
  logic [LOG_D-1:0]  w_unused_dcnt;  // only the drain counter's terminal count matters
  logic              w_dtc;
  logic              w_ph;
  logic [TW_W-1:0]   w_tw_addr;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no latch can form.
    w_adv = 1'b0;
    unique case (r_state)
      S_IDLE, S_PRIME, S_RUN: w_adv = valid_i;
      S_DRAIN:                w_adv = 1'b1;
    endcase
  end

  assign w_drain      = (r_state == S_DRAIN);
  assign w_accept     = valid_i && !w_drain;
  assign w_last_acc   = w_accept && last_i;
  assign w_drain_done = w_drain && w_dtc;

  // Position within the 2D-sample group. Cleared when a drain completes so the
  // next stream's first accept always sees position 0.
  fft_phase_cnt #(.W(CNT_W)) u_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_drain_done),
    .i_en  (w_adv),
    .o_cnt (w_cnt),
    .o_tc  (w_cnt_tc)
  );

  // Drain length counter: D self-advancing cycles after the last accept.
  fft_phase_cnt #(.W(LOG_D)) u_dcnt (
    .clk   (clk),
    .rst   (rst),
    .i_clr (w_last_acc),
    .i_en  (w_drain),
    .o_cnt (w_unused_dcnt),
    .o_tc  (w_dtc)
  );

  assign w_ph      = w_cnt[LOG_D];
  assign w_tw_addr = TW_W'(w_cnt[LOG_D-1:0]) * TW_W'(TW_STRIDE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_data_r  <= '0;
      r_data_i  <= '0;
      r_valid   <= 1'b0;
      r_last    <= 1'b0;
      r_ph      <= 1'b0;
      r_tw_addr <= '0;
      r_tw_conj <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      // Strobes are single-cycle; everything else holds when nothing advances.
      r_valid <= 1'b0;
      r_last  <= 1'b0;

      if (w_adv) begin
        r_ph      <= w_ph;
        r_tw_addr <= w_tw_addr;
        r_data_r  <= w_drain ? '0 : data_in_r;
        r_data_i  <= w_drain ? '0 : data_in_i;
      end

      if (w_last_acc && !w_cnt_tc) begin
        r_err <= 1'b1;
      end

      unique case (r_state)
        S_IDLE, S_PRIME: begin
          if (valid_i) begin
            if (r_state == S_IDLE) begin
              r_tw_conj <= inv_i;
            end
            if (last_i) begin
              r_state <= S_DRAIN;
            end else if (w_cnt == CNT_PRIME_END) begin
              r_state <= S_RUN;
            end else begin
              r_state <= S_PRIME;
            end
          end
        end
        S_RUN: begin
          if (valid_i) begin
            r_valid <= 1'b1;
            if (last_i) begin
              r_state <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          r_valid <= 1'b1;
          if (w_dtc) begin
            r_last  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
      endcase
    end
  end

  assign data_out_r = r_data_r;
  assign data_out_i = r_data_i;
  assign valid_o    = r_valid;
  assign last_o     = r_last;
  assign bf_en      = r_ph;
  assign fb_sel     = r_ph;
  assign tw_addr    = r_tw_addr;
  assign tw_conj    = r_tw_conj;
  assign state      = r_state;
  assign err_o      = r_err;

endmodule

// File: tb/tb_fft_sdf_stage_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fft_sdf_stage_ctrl
//   Directed bench for fft_sdf_stage_ctrl with D=4, N=32 (twiddle stride 4).
//   Output j of a stream of M accepts sits at group position (j+D) mod 2D, so
//   bf_en = position >= D, tw_addr = (position mod D) * 4, and the data is the
//   (j+D+1)-th input for j < M-D, else 0 (drain).
// -----------------------------------------------------------------------------
module tb_fft_sdf_stage_ctrl;

  localparam int DATA_W = 16;
  localparam int LOG_D  = 2;
  localparam int LOG_N  = 5;
  localparam int D      = 1 << LOG_D;
  localparam int STRIDE = 4;
  localparam int PERIOD = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              valid_i;
  logic              last_i;
  logic              inv_i;
  logic [DATA_W-1:0] data_in_r;
  logic [DATA_W-1:0] data_in_i;
  logic [DATA_W-1:0] data_out_r;
  logic [DATA_W-1:0] data_out_i;
  logic              valid_o;
  logic              last_o;
  logic              bf_en;
  logic              fb_sel;
  logic [LOG_N-2:0]  tw_addr;
  logic              tw_conj;
  logic [1:0]        state;
  logic              err_o;

  fft_sdf_stage_ctrl #(.DATA_W(DATA_W), .LOG_D(LOG_D), .LOG_N(LOG_N)) dut (
    .clk        (clk),
    .rst        (rst),
    .valid_i    (valid_i),
    .last_i     (last_i),
    .inv_i      (inv_i),
    .data_in_r  (data_in_r),
    .data_in_i  (data_in_i),
    .data_out_r (data_out_r),
    .data_out_i (data_out_i),
    .valid_o    (valid_o),
    .last_o     (last_o),
    .bf_en      (bf_en),
    .fb_sel     (fb_sel),
    .tw_addr    (tw_addr),
    .tw_conj    (tw_conj),
    .state      (state),
    .err_o      (err_o)
  );

  always #(PERIOD / 2) clk = ~clk;

  typedef struct {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] i;
    logic              bf;
    logic              fb;
    logic [LOG_N-2:0]  tw;
    logic              last;
    logic              conj;
  } out_t;

  out_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   n_last;
  int   n_drain;
  bit   got_first;
  time  t_first;
  time  t_acc;
  time  t_edge;
  bit   chk_hold = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Output monitor, sampling on the falling edge.
  initial begin
    logic             prev_valid;
    logic             prev_bf;
    logic [LOG_N-2:0] prev_tw;
    prev_valid = 1'b0;
    prev_bf    = 1'b0;
    prev_tw    = '0;
    forever begin
      @(negedge clk);
      if (valid_o) begin
        q.push_back('{data_out_r, data_out_i, bf_en, fb_sel, tw_addr, last_o, tw_conj});
        if (!got_first) begin
          got_first = 1'b1;
          t_first   = $time;
        end
      end
      if (last_o) n_last++;
      if (state == 2'd3) n_drain++;
      if (chk_hold && prev_valid && !valid_o) begin
        check("hold_tw", tw_addr, prev_tw);
        check("hold_bf", bf_en, prev_bf);
      end
      prev_valid = valid_o;
      prev_bf    = bf_en;
      prev_tw    = tw_addr;
    end
  end

  task automatic drive(input logic v, input logic l, input logic inv, input int k);
    valid_i   = v;
    last_i    = l;
    inv_i     = inv;
    data_in_r = DATA_W'(k);
    data_in_i = DATA_W'(-k);
    @(posedge clk);
    t_edge = $time;
    #1;
  endtask

  task automatic clear_stream();
    q.delete();
    n_last    = 0;
    n_drain   = 0;
    got_first = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    bit done;
    done = 1'b0;
    for (int k = 0; k < 60 && !done; k++) begin
      @(negedge clk);
      if (state == 2'd0) done = 1'b1;
    end
    if (!done) check({tag, ".timeout"}, 64'd0, 64'd1);
    @(negedge clk);
  endtask

  // m samples, last_i on the m-th; gap inserts an idle cycle between accepts;
  // toggle flips inv_i on alternate samples after the first.
  task automatic run_stream(input string tag, input int m, input bit gap,
                            input bit inv0, input bit toggle);
    clear_stream();
    for (int k = 1; k <= m; k++) begin
      if (gap && k > 1) drive(1'b0, 1'b0, inv0, 0);
      drive(1'b1, k == m, (toggle && k[0] == 1'b0) ? ~inv0 : inv0, k);
      if (k == 1) t_acc = t_edge;
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    wait_idle(tag);
  endtask

  task automatic check_stream(input string tag, input int m, input bit conj,
                              input bit err_exp, input bit chk_lat);
    int               pos;
    logic [DATA_W-1:0] er;
    logic [DATA_W-1:0] ei;
    check({tag, ".count"}, q.size(), m);
    for (int j = 0; j < q.size() && j < m; j++) begin
      pos = (j + D) % (2 * D);
      er  = (j < m - D) ? DATA_W'(j + D + 1)    : '0;
      ei  = (j < m - D) ? DATA_W'(-(j + D + 1)) : '0;
      check($sformatf("%s.re[%0d]", tag, j), q[j].r, er);
      check($sformatf("%s.im[%0d]", tag, j), q[j].i, ei);
      check($sformatf("%s.bf[%0d]", tag, j), q[j].bf, pos >= D);
      check($sformatf("%s.fb[%0d]", tag, j), q[j].fb, pos >= D);
      check($sformatf("%s.tw[%0d]", tag, j), q[j].tw, (pos % D) * STRIDE);
      check($sformatf("%s.last[%0d]", tag, j), q[j].last, j == m - 1);
      check($sformatf("%s.conj[%0d]", tag, j), q[j].conj, conj);
    end
    check({tag, ".n_last"}, n_last, 1);
    check({tag, ".drain_cycles"}, n_drain, D);
    check({tag, ".state"}, state, 0);
    check({tag, ".err"}, err_o, err_exp);
    if (chk_lat) check({tag, ".latency"}, t_first - t_acc, 4 * PERIOD + PERIOD / 2);
  endtask

  initial begin
    rst       = 1'b1;
    valid_i   = 1'b0;
    last_i    = 1'b0;
    inv_i     = 1'b0;
    data_in_r = '0;
    data_in_i = '0;
    clear_stream();

    // 1. Reset, then idle: every output 0.
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rst_outs[%0d]", k),
            {data_out_r, data_out_i, valid_o, last_o, bf_en, fb_sel, tw_addr, tw_conj, state, err_o},
            64'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check($sformatf("idle_outs[%0d]", k),
            {data_out_r, data_out_i, valid_o, last_o, bf_en, fb_sel, tw_addr, tw_conj, state, err_o},
            64'd0);
    end

    // 2. Eight contiguous samples.
    run_stream("t2", 8, 1'b0, 1'b0, 1'b0);
    check_stream("t2", 8, 1'b0, 1'b0, 1'b1);

    // 3. Sixteen samples with an idle cycle between accepts.
    chk_hold = 1'b1;
    run_stream("t3", 16, 1'b1, 1'b0, 1'b0);
    chk_hold = 1'b0;
    check_stream("t3", 16, 1'b0, 1'b0, 1'b0);

    // 4. last_i on sample 6: off a group boundary.
    run_stream("t4", 6, 1'b0, 1'b0, 1'b0);
    check_stream("t4", 6, 1'b0, 1'b1, 1'b0);

    // 5. Inverse captured at first accept, then a forward stream.
    run_stream("t5a", 8, 1'b0, 1'b1, 1'b1);
    check_stream("t5a", 8, 1'b1, 1'b1, 1'b0);
    run_stream("t5b", 8, 1'b0, 1'b0, 1'b1);
    check_stream("t5b", 8, 1'b0, 1'b1, 1'b0);

    // 6. Reset after sample 5, then a fresh stream.
    for (int k = 1; k <= 5; k++) drive(1'b1, 1'b0, 1'b0, k);
    valid_i = 1'b0;
    rst     = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t6.abort_valid", valid_o, 0);
    check("t6.abort_state", state, 0);
    check("t6.abort_outs",
          {data_out_r, data_out_i, valid_o, last_o, bf_en, fb_sel, tw_addr, tw_conj, state, err_o},
          64'd0);
    repeat (3) @(negedge clk);
    run_stream("t6", 8, 1'b0, 1'b0, 1'b0);
    check_stream("t6", 8, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
